// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path: wire-format modes, run/idle state encoding
// and a parameter-legality check used at elaboration.
package i2s_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic bit params_ok(input int data_w, input int slot_w,
                                   input int bclk_div, input int mode);
    return (data_w >= 1) && (data_w <= slot_w) &&
           (slot_w >= 8) && (slot_w <= 32) &&
           (bclk_div >= 1) &&
           ((mode == MODE_I2S) || (mode == MODE_LJ));
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator: divides clk down to a registered bclk and flags the clk cycles in
// which bclk is about to fall or rise, so all serial logic stays in the clk domain.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap     = run && (cnt == CNT_MAX);
  assign fall_stb = wrap && bclk;
  assign rise_stb = wrap && !bclk;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt  <= '0;
      bclk <= !bclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_master.sv
// Stereo I2S / left-justified transmitter: one-deep holding register on a valid/ready input,
// frame loads at bit index 0, outputs updated only on the bclk falling strobe.
module i2s_tx_master
  import i2s_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 16,
  parameter int MODE     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_start,
  output logic              underflow
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int K_W        = $clog2(FRAME_BITS);
  localparam int IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_BITS - 1);

  if (!params_ok(DATA_W, SLOT_W, BCLK_DIV, MODE)) begin : g_bad_params
    $error("i2s_tx_master: illegal parameter combination");
  end

  state_e            state, state_nxt;
  logic              run;
  logic              fall_stb;
  logic [K_W-1:0]    k;
  logic              hold_full;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic [DATA_W-1:0] frame_l, frame_r;
  logic [DATA_W-1:0] src_l, src_r;
  logic              lj_bit, lj_lr;
  logic              dly_bit, dly_lr;
  logic              xfer, load;
  int                pos;
  logic [IDX_W-1:0]  idx;

  i2s_clk_gen #(.BCLK_DIV(BCLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .bclk     (bclk),
    .fall_stb (fall_stb),
    .rise_stb ()
  );

  // Dropping en stops the divider on the same edge the FSM returns to IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    state_nxt = state;
    run       = 1'b0;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN: begin
        run = en;
        if (!en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign s_ready = !hold_full;
  assign xfer    = s_valid && !hold_full;
  assign load    = fall_stb && (k == '0);

  // At k=0 the bit comes straight from the holding register being loaded this strobe.
  always_comb begin
    src_l = frame_l;
    src_r = frame_r;
    if (k == '0) begin
      src_l = hold_full ? hold_l : '0;
      src_r = hold_full ? hold_r : '0;
    end
    lj_lr  = (int'(k) >= SLOT_W);
    pos    = lj_lr ? (int'(k) - SLOT_W) : int'(k);
    idx    = IDX_W'(DATA_W - 1 - pos);
    lj_bit = 1'b0;
    if (pos < DATA_W) lj_bit = lj_lr ? src_r[idx] : src_l[idx];
  end

  // A transfer coinciding with a load never bypasses: it refills the register after the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (xfer) begin
      hold_full <= 1'b1;
      hold_l    <= s_left;
      hold_r    <= s_right;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      frame_l     <= '0;
      frame_r     <= '0;
      dly_bit     <= 1'b0;
      dly_lr      <= 1'b0;
      sdata       <= 1'b0;
      lrclk       <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      if (!run) begin
        k       <= '0;
        frame_l <= '0;
        frame_r <= '0;
        dly_bit <= 1'b0;
        dly_lr  <= 1'b0;
        sdata   <= 1'b0;
        lrclk   <= 1'b0;
      end else if (fall_stb) begin
        k <= (k == K_LAST) ? '0 : k + 1'b1;
        if (k == '0) begin
          frame_l     <= src_l;
          frame_r     <= src_r;
          frame_start <= 1'b1;
          underflow   <= !hold_full;
        end
        if (MODE == MODE_I2S) begin
          sdata   <= dly_bit;
          lrclk   <= dly_lr;
          dly_bit <= lj_bit;
          dly_lr  <= lj_lr;
        end else begin
          sdata <= lj_bit;
          lrclk <= lj_lr;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Scoreboard bench: one LJ and one I2S instance share stimulus; a negedge monitor rebuilds the
// expected serial stream from accepted sample pairs and the frame bit-layout rules.
module tb_i2s_tx_master;

  localparam int DATA_W    = 24;
  localparam int SLOT_W    = 32;
  localparam int DIV       = 2;
  localparam int FRAME     = 2 * SLOT_W;
  localparam int FRAME_CLK = 2 * FRAME * DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_left = '0;
  logic [DATA_W-1:0] s_right = '0;
  logic [1:0]        s_ready, bclk, lrclk, sdata, frame_start, underflow;

  i2s_tx_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(DIV), .MODE(1)) dut_lj (
    .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready[0]),
    .s_left(s_left), .s_right(s_right), .bclk(bclk[0]), .lrclk(lrclk[0]),
    .sdata(sdata[0]), .frame_start(frame_start[0]), .underflow(underflow[0])
  );

  i2s_tx_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(DIV), .MODE(0)) dut_i2s (
    .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready[1]),
    .s_left(s_left), .s_right(s_right), .bclk(bclk[1]), .lrclk(lrclk[1]),
    .sdata(sdata[1]), .frame_start(frame_start[1]), .underflow(underflow[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    int unsigned       cyc;
  } pair_t;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          xfers = 0;
  pair_t       pend_q[2][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Left-justified bit k of a frame: slot k/SLOT_W, MSB first, zero padded after the LSB.
  function automatic logic lj_ref(input pair_t p, input int kk);
    int                slot = kk / SLOT_W;
    int                pidx = kk % SLOT_W;
    logic [DATA_W-1:0] w;
    if (pidx >= DATA_W) return 1'b0;
    w = (slot != 0) ? p.r : p.l;
    w = w >> (DATA_W - 1 - pidx);
    return w[0];
  endfunction

  // Handshake observer: records every accepted pair with the cycle it was accepted in.
  always @(posedge clk) begin
    pair_t p;
    cyc++;
    if (rst_n) begin
      p.l = s_left;
      p.r = s_right;
      p.cyc = cyc;
      for (int d = 0; d < 2; d++)
        if (s_valid && s_ready[d]) pend_q[d].push_back(p);
      if (s_valid && s_ready[0]) xfers++;
    end
  end

  // Monitor state per DUT (0 = LJ, 1 = I2S).
  logic        bclk_p[2];
  int          fall_cnt[2];
  int          run_len[2];
  bit          first_edge[2];
  logic        prev_b[2];
  logic        prev_lr[2];
  pair_t       cur[2];
  int unsigned last_fs[2];
  bit          fs_valid[2];
  logic        en_last = 1'b0;
  int          mon_k = -1;

  always @(negedge clk) begin
    int   mk;
    bit   m_uf;
    logic m_b, m_lr;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || !en_last) begin
        if (rst_n)
          check($sformatf("d%0d_idle_outputs", d),
                {bclk[d], lrclk[d], sdata[d], frame_start[d], underflow[d]}, 5'b0);
        else
          pend_q[d].delete();
        bclk_p[d] = 1'b0;
        fall_cnt[d] = 0;
        run_len[d] = 0;
        first_edge[d] = 1'b1;
        prev_b[d] = 1'b0;
        prev_lr[d] = 1'b0;
        fs_valid[d] = 1'b0;
        cur[d] = '{l: '0, r: '0, cyc: 0};
        if (d == 0) mon_k = -1;
      end else begin
        if (bclk[d] !== bclk_p[d]) begin
          if (!first_edge[d]) check($sformatf("d%0d_bclk_half_period", d), run_len[d], DIV);
          first_edge[d] = 1'b0;
          run_len[d] = 1;
        end else begin
          run_len[d]++;
        end
        if (bclk_p[d] && !bclk[d]) begin
          mk = fall_cnt[d] % FRAME;
          fall_cnt[d]++;
          m_uf = 1'b0;
          if (mk == 0) begin
            m_uf = !(pend_q[d].size() > 0 && pend_q[d][0].cyc < cyc);
            if (m_uf) cur[d] = '{l: '0, r: '0, cyc: 0};
            else      cur[d] = pend_q[d].pop_front();
            if (fs_valid[d]) check($sformatf("d%0d_frame_period", d), cyc - last_fs[d], FRAME_CLK);
            last_fs[d] = cyc;
            fs_valid[d] = 1'b1;
          end
          check($sformatf("d%0d_frame_start_k%0d", d, mk), frame_start[d], mk == 0);
          check($sformatf("d%0d_underflow_k%0d", d, mk), underflow[d], m_uf);
          m_b = lj_ref(cur[d], mk);
          m_lr = (mk >= SLOT_W);
          if (d == 0) check($sformatf("d0_lj_bits_k%0d", mk), {lrclk[d], sdata[d]}, {m_lr, m_b});
          else        check($sformatf("d1_i2s_bits_k%0d", mk), {lrclk[d], sdata[d]}, {prev_lr[d], prev_b[d]});
          prev_b[d] = m_b;
          prev_lr[d] = m_lr;
          if (d == 0) mon_k = mk;
        end else begin
          check($sformatf("d%0d_no_pulse", d), {frame_start[d], underflow[d]}, 2'b00);
        end
        bclk_p[d] = bclk[d];
      end
      if (rst_n) check($sformatf("d%0d_s_ready", d), s_ready[d], pend_q[d].size() == 0);
    end
    en_last = rst_n ? en : 1'b0;
  end

  task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int start = xfers;
    bit done = 1'b0;
    s_valid = 1'b1;
    s_left = l;
    s_right = r;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      @(posedge clk); #1;
      if (xfers != start) begin
        done = 1'b1;
        break;
      end
    end
    check("send_pair_accepted", done, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic wait_k(input int target);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      @(posedge clk); #1;
      if (mon_k == target) begin
        hit = 1'b1;
        break;
      end
    end
    check($sformatf("reach_k%0d", target), hit, 1'b1);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;

    // Reset values while rst_n is held low.
    run_cycles(3);
    check("reset_outputs", {bclk, lrclk, sdata, frame_start, underflow}, 10'b0);
    check("reset_s_ready", s_ready, 2'b11);
    rst_n = 1'b1;
    run_cycles(2);
    en = 1'b1;

    // Fixed pattern through both wire formats, followed by frames with no data (underflow).
    send_pair(24'hA5A5A5, 24'h5A5A5A);
    run_cycles(4 * FRAME_CLK);

    // Continuous valid: fresh random data after each accepted pair.
    s_valid = 1'b1;
    s_left = DATA_W'($urandom);
    s_right = DATA_W'($urandom);
    seen = xfers;
    for (int i = 0; i < 4 * FRAME_CLK; i++) begin
      @(posedge clk); #1;
      if (xfers != seen) begin
        seen = xfers;
        s_left = DATA_W'($urandom);
        s_right = DATA_W'($urandom);
      end
    end

    // Sporadic valid with random data, including valid dropping without a transfer.
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      s_valid = ($urandom_range(0, 3) == 0);
      s_left = DATA_W'($urandom);
      s_right = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;

    // Abort at k=40 with a pair held, then restart.
    wait_k(2);
    send_pair(DATA_W'($urandom), DATA_W'($urandom));
    wait_k(40);
    en = 1'b0;
    run_cycles(10);
    en = 1'b1;
    run_cycles(2 * FRAME_CLK);

    // Asynchronous reset mid-frame with the holding register full.
    wait_k(2);
    send_pair(DATA_W'($urandom), DATA_W'($urandom));
    wait_k(20);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bclk, lrclk, sdata, frame_start, underflow}, 10'b0);
    check("async_reset_s_ready", s_ready, 2'b11);
    en = 1'b0;
    run_cycles(2);
    rst_n = 1'b1;
    run_cycles(1);
    check("post_reset_s_ready", s_ready, 2'b11);
    en = 1'b1;
    send_pair(DATA_W'($urandom), DATA_W'($urandom));
    run_cycles(2 * FRAME_CLK);
    en = 1'b0;
    run_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
